hamming_secded_decoder: RTL and testbench

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

---
 rtl/hamming_secded_decoder_if.sv | 59 +++++
 rtl/hamming_secded_decoder.sv | 171 +++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_decoder_if.sv
// Bundles the streaming handshake, codeword, decoded result and error
// counter signals of hamming_secded_decoder into one interface. clk and
// rst are not part of it and stay plain ports of the decoder.
//
// Signals:
//   in_valid / in_ready / in_codeword      : input codeword handshake (N bits)
//   out_valid / out_ready                  : output word handshake
//   out_data                               : corrected payload (DATA_W bits)
//   out_syndrome                           : raw syndrome (R bits)
//   out_corrected / out_uncorrectable      : classification flags
//   clear_counts                           : synchronous clear of both counters
//   corr_count / uncorr_count              : delivered-word error counters
// Modports:
//   master : the producer/consumer side (testbench or surrounding logic)
//   slave  : the decoder side
interface hamming_secded_decoder_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);

    // Smallest R with 2^R >= DATA_W + R + 1.
    function automatic int calcR(input int dw);
        int r;
        r = 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    localparam int R = calcR(DATA_W);
    localparam int N = DATA_W + R + 1;

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_codeword;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [R-1:0]      out_syndrome;
    logic              out_corrected;
    logic              out_uncorrectable;
    logic              clear_counts;
    logic [CNT_W-1:0]  corr_count;
    logic [CNT_W-1:0]  uncorr_count;

    modport master (
        output in_valid, in_codeword, out_ready, clear_counts,
        input  in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable, corr_count, uncorr_count
    );

    modport slave (
        input  in_valid, in_codeword, out_ready, clear_counts,
        output in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable, corr_count, uncorr_count
    );

endinterface

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready flow control
// and saturating counters of corrected and uncorrectable delivered words.
//
// Codeword layout: bit i-1 holds Hamming position i (1..N-1), parity bits
// sit at power-of-two positions, data bits fill the remaining positions in
// ascending order, and bit N-1 is overall even parity.
//
// Ports:
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset
//   bus : hamming_secded_decoder_if slave modport (handshakes, codeword,
//         decoded outputs, counter clear and counters)
module hamming_secded_decoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    hamming_secded_decoder_if.slave bus
);

    function automatic int calcR(input int dw);
        int r;
        r = 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    // Hamming position of data bit d (skips the power-of-two parity slots).
    function automatic int dataPos(input int d);
        int result;
        int seen;
        result = 0;
        seen   = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (seen == d) result = p;
                seen = seen + 1;
            end
        end
        return result;
    endfunction

    localparam int R = calcR(DATA_W);
    localparam int N = DATA_W + R + 1;

    logic              w_en;
    logic [R-1:0]      w_syn;
    logic              w_p;
    logic [N-1:0]      w_fixed;
    logic [DATA_W-1:0] w_data;
    logic              w_corr;
    logic              w_uncorr;
    logic              w_outFire;

    logic              r_s1Valid;
    logic [N-1:0]      r_s1Code;
    logic [R-1:0]      r_s1Syn;
    logic              r_s1P;
    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [R-1:0]      r_outSyn;
    logic              r_outCorr;
    logic              r_outUncorr;
    logic [CNT_W-1:0]  r_corrCount;
    logic [CNT_W-1:0]  r_uncorrCount;

    // The whole pipeline moves as one: it advances whenever the output
    // register is empty or being consumed, so no per-stage skid is needed.
    assign w_en      = ~r_outValid | bus.out_ready;
    assign w_outFire = r_outValid & bus.out_ready;

    // Syndrome and overall parity straight from the incoming codeword.
    always_comb begin
        w_syn = '0;
        for (int j = 0; j < R; j++) begin
            for (int i = 1; i < N; i++) begin
                if (((i >> j) & 1) == 1) w_syn[j] = w_syn[j] ^ bus.in_codeword[i-1];
            end
        end
        w_p = ^bus.in_codeword;
    end

    // Classification and single-bit repair of the stage-1 codeword. A
    // syndrome of zero with bad overall parity means only the overall parity
    // bit flipped, so nothing in the payload needs touching.
    always_comb begin
        w_fixed  = r_s1Code;
        w_corr   = 1'b0;
        w_uncorr = 1'b0;
        if (r_s1P) begin
            if (int'(r_s1Syn) <= N - 1) begin
                w_corr = 1'b1;
                for (int i = 1; i < N; i++) begin
                    if (int'(r_s1Syn) == i) w_fixed[i-1] = ~w_fixed[i-1];
                end
            end else begin
                w_uncorr = 1'b1;
            end
        end else if (r_s1Syn != '0) begin
            w_uncorr = 1'b1;
        end
    end

    // Payload extraction; for uncorrectable words w_fixed is still the raw
    // codeword, so this yields the uncorrected data.
    always_comb begin
        w_data = '0;
        for (int d = 0; d < DATA_W; d++) begin
            w_data[d] = w_fixed[dataPos(d) - 1];
        end
    end

    // Stage 1: capture codeword with its syndrome and overall parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Code  <= '0;
            r_s1Syn   <= '0;
            r_s1P     <= 1'b0;
        end else if (w_en) begin
            r_s1Valid <= bus.in_valid;
            r_s1Code  <= bus.in_codeword;
            r_s1Syn   <= w_syn;
            r_s1P     <= w_p;
        end
    end

    // Stage 2: decoded result; holds steady while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outSyn    <= '0;
            r_outCorr   <= 1'b0;
            r_outUncorr <= 1'b0;
        end else if (w_en) begin
            r_outValid  <= r_s1Valid;
            r_outData   <= w_data;
            r_outSyn    <= r_s1Syn;
            r_outCorr   <= w_corr;
            r_outUncorr <= w_uncorr;
        end
    end

    // Counters only see delivered words; clear wins over a same-cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corrCount   <= '0;
            r_uncorrCount <= '0;
        end else if (bus.clear_counts) begin
            r_corrCount   <= '0;
            r_uncorrCount <= '0;
        end else if (w_outFire) begin
            if (r_outCorr && (r_corrCount != '1))     r_corrCount   <= r_corrCount + CNT_W'(1);
            if (r_outUncorr && (r_uncorrCount != '1)) r_uncorrCount <= r_uncorrCount + CNT_W'(1);
        end
    end

    assign bus.in_ready          = w_en;
    assign bus.out_valid         = r_outValid;
    assign bus.out_data          = r_outData;
    assign bus.out_syndrome      = r_outSyn;
    assign bus.out_corrected     = r_outCorr;
    assign bus.out_uncorrectable = r_outUncorr;
    assign bus.corr_count        = r_corrCount;
    assign bus.uncorr_count      = r_uncorrCount;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_W=8, R=4, N=13).
// A table of hand-encoded codewords is streamed back-to-back, followed by
// hand-written sequences for stalls, counter saturation/clear (second
// instance with CNT_W=2) and reset with words in flight.
module tb_hamming_secded_decoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hamming_secded_decoder_if #(.DATA_W(8), .CNT_W(16)) bus ();
    hamming_secded_decoder_if #(.DATA_W(8), .CNT_W(2))  bus2 ();

    hamming_secded_decoder #(.DATA_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hamming_secded_decoder #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        string       name;
        logic [12:0] cw;
        logic [7:0]  data;
        logic [3:0]  syn;
        logic        corr;
        logic        uncorr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int checkCount = 0;
    int errorCount = 0;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [12:0] cw);
        bus.in_valid    = valid;
        bus.in_codeword = cw;
    endtask

    task automatic applyStimulus2(input logic valid, input logic [12:0] cw);
        bus2.in_valid    = valid;
        bus2.in_codeword = cw;
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".valid"},  32'(bus.out_valid),         32'd1);
        checkOutput({v.name, ".data"},   32'(bus.out_data),          32'(v.data));
        checkOutput({v.name, ".syn"},    32'(bus.out_syndrome),      32'(v.syn));
        checkOutput({v.name, ".corr"},   32'(bus.out_corrected),     32'(v.corr));
        checkOutput({v.name, ".uncorr"}, 32'(bus.out_uncorrectable), 32'(v.uncorr));
    endtask

    // Keeps a broken design from hanging the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expCorr;
        int expUncorr;
        int sent;
        int got;
        logic ready;
        logic prevStall;
        logic [7:0] prevData;
        logic [7:0] expQ [$];
        int streamIdx [4];

        // Hand-encoded vectors. 0xA5 encodes to 0x0A27, 0xFF to 0x0F77,
        // 0x3C to 0x1362, 0x00 to 0x0000.
        vecs[0]  = '{"clean_a5",   13'h0A27, 8'hA5, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{"a5_flip4",   13'h0A37, 8'hA5, 4'h5, 1'b1, 1'b0};
        vecs[2]  = '{"a5_flip12",  13'h1A27, 8'hA5, 4'h0, 1'b1, 1'b0};
        vecs[3]  = '{"a5_dbl2_5",  13'h0A03, 8'hA0, 4'h5, 1'b0, 1'b1};
        vecs[4]  = '{"a5_synd13",  13'h0AAE, 8'hA5, 4'hD, 1'b0, 1'b1};
        vecs[5]  = '{"clean_00",   13'h0000, 8'h00, 4'h0, 1'b0, 1'b0};
        vecs[6]  = '{"clean_ff",   13'h0F77, 8'hFF, 4'h0, 1'b0, 1'b0};
        vecs[7]  = '{"ff_pos8",    13'h0FF7, 8'hFF, 4'h8, 1'b1, 1'b0};
        vecs[8]  = '{"ff_pos12",   13'h0777, 8'hFF, 4'hC, 1'b1, 1'b0};
        vecs[9]  = '{"ff_dbl1_2",  13'h0F74, 8'hFF, 4'h3, 1'b0, 1'b1};
        vecs[10] = '{"clean_3c",   13'h1362, 8'h3C, 4'h0, 1'b0, 1'b0};
        vecs[11] = '{"3c_pos3",    13'h1366, 8'h3C, 4'h3, 1'b1, 1'b0};

        expCorr   = 0;
        expUncorr = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].corr)   expCorr++;
            if (vecs[i].uncorr) expUncorr++;
        end

        rst = 1'b1;
        applyStimulus(1'b0, '0);
        bus.out_ready     = 1'b1;
        bus.clear_counts  = 1'b0;
        applyStimulus2(1'b0, '0);
        bus2.out_ready    = 1'b1;
        bus2.clear_counts = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst.out_valid", 32'(bus.out_valid),    32'd0);
        checkOutput("rst.in_ready",  32'(bus.in_ready),     32'd1);
        checkOutput("rst.out_data",  32'(bus.out_data),     32'd0);
        checkOutput("rst.syndrome",  32'(bus.out_syndrome), 32'd0);
        checkOutput("rst.corr_cnt",  32'(bus.corr_count),   32'd0);
        checkOutput("rst.uncorr_cnt",32'(bus.uncorr_count), 32'd0);
        rst = 1'b0;

        // Back-to-back stream of the table: two-cycle latency, one per cycle.
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            if (k >= 2) checkVector(vecs[k-2]);
            else        checkOutput("latency.out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("stream.in_ready", 32'(bus.in_ready), 32'd1);
            if (k < NV) applyStimulus(1'b1, vecs[k].cw);
            else        applyStimulus(1'b0, '0);
        end
        @(negedge clk);
        checkOutput("bubble.out_valid",  32'(bus.out_valid),    32'd0);
        checkOutput("stream.corr_cnt",   32'(bus.corr_count),   32'(expCorr));
        checkOutput("stream.uncorr_cnt", 32'(bus.uncorr_count), 32'(expUncorr));
        @(negedge clk);
        checkOutput("bubble.corr_cnt",   32'(bus.corr_count),   32'(expCorr));

        // Counter clear.
        bus.clear_counts = 1'b1;
        @(negedge clk);
        bus.clear_counts = 1'b0;
        checkOutput("clear.corr_cnt",   32'(bus.corr_count),   32'd0);
        checkOutput("clear.uncorr_cnt", 32'(bus.uncorr_count), 32'd0);

        // Four words with a three-cycle downstream stall in the middle.
        streamIdx = '{0, 5, 6, 10};
        sent      = 0;
        got       = 0;
        prevStall = 1'b0;
        prevData  = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (prevStall) begin
                checkOutput("stall.hold_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("stall.hold_data",  32'(bus.out_data),  32'(prevData));
            end
            ready = !(c >= 3 && c <= 5);
            bus.out_ready = ready;
            #1;
            if (bus.out_valid && ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("stall.extra_word", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("stall.order_data", 32'(bus.out_data), 32'(expQ.pop_front()));
                end
                got++;
            end
            if (!ready && bus.out_valid) checkOutput("stall.in_ready", 32'(bus.in_ready), 32'd0);
            prevStall = bus.out_valid && !ready;
            prevData  = bus.out_data;
            if (bus.in_ready) begin
                if (sent < 4) begin
                    applyStimulus(1'b1, vecs[streamIdx[sent]].cw);
                    expQ.push_back(vecs[streamIdx[sent]].data);
                    sent++;
                end else begin
                    applyStimulus(1'b0, '0);
                end
            end
        end
        checkOutput("stall.delivered", 32'(got),         32'd4);
        checkOutput("stall.leftover",  32'(expQ.size()), 32'd0);
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, '0);

        // Saturation on the CNT_W=2 instance.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            applyStimulus2(1'b1, 13'h0A37);
        end
        @(negedge clk);
        applyStimulus2(1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("sat.corr_cnt",   32'(bus2.corr_count),   32'd3);
        checkOutput("sat.uncorr_cnt", 32'(bus2.uncorr_count), 32'd0);

        // Clear coincident with a corrected handshake.
        applyStimulus2(1'b1, 13'h0A37);
        @(negedge clk);
        applyStimulus2(1'b0, '0);
        @(negedge clk);
        checkOutput("clrhs.out_valid", 32'(bus2.out_valid),     32'd1);
        checkOutput("clrhs.corrected", 32'(bus2.out_corrected), 32'd1);
        bus2.clear_counts = 1'b1;
        @(negedge clk);
        bus2.clear_counts = 1'b0;
        checkOutput("clrhs.corr_cnt", 32'(bus2.corr_count), 32'd0);

        // One corrected word delivered so the counter is non-zero before reset.
        bus.clear_counts = 1'b1;
        @(negedge clk);
        bus.clear_counts = 1'b0;
        applyStimulus(1'b1, 13'h0A37);
        @(negedge clk);
        applyStimulus(1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("single.corr_cnt", 32'(bus.corr_count), 32'd1);

        // Reset with two words in flight.
        applyStimulus(1'b1, 13'h0A37);
        @(negedge clk);
        applyStimulus(1'b1, 13'h1A27);
        @(negedge clk);
        applyStimulus(1'b0, '0);
        checkOutput("inflight.out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.out_valid",  32'(bus.out_valid),     32'd0);
        checkOutput("arst.in_ready",   32'(bus.in_ready),      32'd1);
        checkOutput("arst.out_data",   32'(bus.out_data),      32'd0);
        checkOutput("arst.corrected",  32'(bus.out_corrected), 32'd0);
        checkOutput("arst.corr_cnt",   32'(bus.corr_count),    32'd0);
        checkOutput("arst.corr_cnt2",  32'(bus2.corr_count),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst.flushed", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b1, vecs[11].cw);
        @(negedge clk);
        applyStimulus(1'b0, '0);
        checkOutput("postrst.lat1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkVector(vecs[11]);
        @(negedge clk);
        checkOutput("postrst.corr_cnt", 32'(bus.corr_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
